// File: rtl/oled_pkg.sv
// Shared frame geometry and FSM encoding for the OLED double-buffered framebuffer.
package oled_pkg;

  localparam int FB_BYTES = 1024;
  localparam int ADDR_W   = $clog2(FB_BYTES);

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port byte RAM holding both frame banks: one write port, one registered read port.
module fb_dpram
  import oled_pkg::*;
#(
  parameter int AW = ADDR_W + 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // NOTE: the array and its read register are deliberately left without reset so they
  // map onto block RAM; the top masks read data until a complete frame is on display.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/oled_frame_buffer.sv
// Double-buffered framebuffer: fills the back bank from a byte stream, serves the display
// driver from the front bank, and swaps banks only on the driver's 1023 -> 0 address wrap.
module oled_frame_buffer
  import oled_pkg::*;
#(
  parameter int FRAME_BYTES = FB_BYTES,
  parameter int FRAME_AW    = $clog2(FRAME_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          inData,
  input  logic                inValid,
  output logic                inReady,
  input  logic                frameStart,
  input  logic [FRAME_AW-1:0] pixelAddress,
  output logic [7:0]          pixelData,
  output logic                frameDone,
  output logic                activeBank,
  output logic [7:0]          frameCount
);

  localparam logic [FRAME_AW-1:0] LAST_ADDR = FRAME_AW'(FRAME_BYTES - 1);
  localparam logic [FRAME_AW-1:0] ONE       = FRAME_AW'(1);

  fb_state_e           r_state;
  fb_state_e           w_state_next;
  logic [FRAME_AW-1:0] r_wr_ptr;
  logic [FRAME_AW-1:0] w_wr_ptr_next;
  logic [FRAME_AW-1:0] w_wr_addr;
  logic [FRAME_AW-1:0] r_prev_addr;
  logic                r_active_bank;
  logic                r_shown;
  logic                r_frame_done;
  logic [7:0]          r_frame_count;
  logic                w_we;
  logic                w_wrap;
  logic                w_swap;
  logic                w_read_bank;
  logic [7:0]          w_rd_data;

  assign w_wrap = (r_prev_addr == LAST_ADDR) && (pixelAddress == '0);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_wr_addr     = r_wr_ptr;
    w_we          = 1'b0;
    w_swap        = 1'b0;
    inReady       = 1'b0;
    case (r_state)
      FILL: begin
        inReady = 1'b1;
        if (frameStart) begin
          w_wr_addr     = '0;
          w_wr_ptr_next = '0;
        end
        if (inValid) begin
          w_we = 1'b1;
          if (frameStart) begin
            w_wr_ptr_next = ONE;
          end else if (r_wr_ptr == LAST_ADDR) begin
            w_wr_ptr_next = '0;
            w_state_next  = WAIT_SWAP;
          end else begin
            w_wr_ptr_next = r_wr_ptr + ONE;
          end
        end
      end
      WAIT_SWAP: begin
        if (w_wrap) begin
          w_swap       = 1'b1;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_prev_addr   <= '0;
      r_active_bank <= 1'b0;
      r_shown       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_next;
      r_prev_addr  <= pixelAddress;
      r_frame_done <= w_swap;
      if (w_swap) begin
        r_active_bank <= ~r_active_bank;
        r_shown       <= 1'b1;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // On the swap edge, address 0 of the new frame must already come from the new bank.
  assign w_read_bank = w_swap ? ~r_active_bank : r_active_bank;

  fb_dpram #(
    .AW (FRAME_AW + 1)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr ({~r_active_bank, w_wr_addr}),
    .i_wr_data (inData),
    .i_rd_addr ({w_read_bank, pixelAddress}),
    .o_rd_data (w_rd_data)
  );

  assign pixelData  = r_shown ? w_rd_data : 8'h00;
  assign frameDone  = r_frame_done;
  assign activeBank = r_active_bank;
  assign frameCount = r_frame_count;

endmodule

// File: tb/tb_oled_frame_buffer.sv
// Directed bench for oled_frame_buffer: full-size instance for data paths, a 4-byte instance
// to walk the frame counter through its wrap quickly.
module tb_oled_frame_buffer;

  localparam int FB = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    inData = 8'h00;
  logic          inValid = 1'b0;
  logic          frameStart = 1'b0;
  logic [AW-1:0] pixelAddress = '0;
  logic          inReady;
  logic [7:0]    pixelData;
  logic          frameDone;
  logic          activeBank;
  logic [7:0]    frameCount;

  logic [7:0]    s_inData = 8'h00;
  logic          s_inValid = 1'b0;
  logic          s_frameStart = 1'b0;
  logic [1:0]    s_pixelAddress = 2'd0;
  logic          s_inReady;
  logic [7:0]    s_pixelData;
  logic          s_frameDone;
  logic          s_activeBank;
  logic [7:0]    s_frameCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oled_frame_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .inData       (inData),
    .inValid      (inValid),
    .inReady      (inReady),
    .frameStart   (frameStart),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData),
    .frameDone    (frameDone),
    .activeBank   (activeBank),
    .frameCount   (frameCount)
  );

  oled_frame_buffer #(.FRAME_BYTES(4)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .inData       (s_inData),
    .inValid      (s_inValid),
    .inReady      (s_inReady),
    .frameStart   (s_frameStart),
    .pixelAddress (s_pixelAddress),
    .pixelData    (s_pixelData),
    .frameDone    (s_frameDone),
    .activeBank   (s_activeBank),
    .frameCount   (s_frameCount)
  );

  // Streams n bytes for addresses start.., data = addr[7:0] ^ xv; returns with inValid low.
  task automatic feed(input int n, input int start, input logic [7:0] xv);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'(start + k) ^ xv;
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Driver sweep over addresses 1..FB-1, one clock each.
  task automatic sweep(input bit chk_zero, input bit chk_busy);
    for (int i = 1; i < FB; i++) begin
      @(negedge clk);
      n_cmp++;
      if (frameDone !== 1'b0) begin
        n_err++; $display("FAIL sweep_frameDone addr=%0d: got %b want 0", i, frameDone);
      end
      if (chk_zero) begin
        n_cmp++;
        if (pixelData !== 8'h00) begin
          n_err++; $display("FAIL sweep_pixelData addr=%0d: got %h want 00", i, pixelData);
        end
      end
      if (chk_busy) begin
        n_cmp++;
        if (inReady !== 1'b0) begin
          n_err++; $display("FAIL sweep_inReady addr=%0d: got %b want 0", i, inReady);
        end
      end
      pixelAddress = AW'(i);
    end
  endtask

  // Drives address 0 after 1023; returns at the negedge following the wrap edge.
  task automatic wrap_addr();
    @(negedge clk);
    pixelAddress = '0;
    @(negedge clk);
  endtask

  task automatic read_at(input int a, output logic [7:0] v);
    @(negedge clk);
    pixelAddress = AW'(a);
    @(negedge clk);
    v = pixelData;
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 5;
    if (inReady !== 1'b1)     begin n_err++; $display("FAIL reset_inReady: got %b want 1", inReady); end
    if (pixelData !== 8'h00)  begin n_err++; $display("FAIL reset_pixelData: got %h want 00", pixelData); end
    if (activeBank !== 1'b0)  begin n_err++; $display("FAIL reset_activeBank: got %b want 0", activeBank); end
    if (frameCount !== 8'h00) begin n_err++; $display("FAIL reset_frameCount: got %0d want 0", frameCount); end
    if (frameDone !== 1'b0)   begin n_err++; $display("FAIL reset_frameDone: got %b want 0", frameDone); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_frame_and_backpressure();
    logic [7:0] v;
    feed(FB, 0, 8'h00);
    n_cmp++;
    if (inReady !== 1'b0) begin n_err++; $display("FAIL first_inReady_after_last: got %b want 0", inReady); end
    inValid = 1'b1;
    inData  = 8'hAA;
    sweep(1'b1, 1'b1);
    wrap_addr();
    n_cmp += 5;
    if (frameDone !== 1'b1)   begin n_err++; $display("FAIL first_swap_frameDone: got %b want 1", frameDone); end
    if (activeBank !== 1'b1)  begin n_err++; $display("FAIL first_swap_activeBank: got %b want 1", activeBank); end
    if (frameCount !== 8'd1)  begin n_err++; $display("FAIL first_swap_frameCount: got %0d want 1", frameCount); end
    if (inReady !== 1'b1)     begin n_err++; $display("FAIL first_swap_inReady: got %b want 1", inReady); end
    if (pixelData !== 8'h00)  begin n_err++; $display("FAIL first_swap_pixel0: got %h want 00", pixelData); end
    @(negedge clk);
    inValid = 1'b0;
    n_cmp++;
    if (frameDone !== 1'b0) begin n_err++; $display("FAIL first_frameDone_width: got %b want 0", frameDone); end
    read_at(5, v);
    n_cmp++;
    if (v !== 8'h05) begin n_err++; $display("FAIL first_read5: got %h want 05", v); end
    read_at(1023, v);
    n_cmp++;
    if (v !== 8'hFF) begin n_err++; $display("FAIL first_read1023: got %h want ff", v); end
    read_at(0, v);
    n_cmp += 2;
    if (v !== 8'h00) begin n_err++; $display("FAIL backpressure_bank1_addr0: got %h want 00", v); end
    if (frameDone !== 1'b0) begin n_err++; $display("FAIL fill_wrap_no_swap: got %b want 0", frameDone); end
  endtask

  task automatic test_second_frame();
    logic [7:0] v;
    feed(FB - 1, 1, 8'hFF);
    n_cmp++;
    if (inReady !== 1'b0) begin n_err++; $display("FAIL second_inReady_after_last: got %b want 0", inReady); end
    sweep(1'b0, 1'b1);
    wrap_addr();
    n_cmp += 4;
    if (frameDone !== 1'b1)  begin n_err++; $display("FAIL second_swap_frameDone: got %b want 1", frameDone); end
    if (activeBank !== 1'b0) begin n_err++; $display("FAIL second_swap_activeBank: got %b want 0", activeBank); end
    if (frameCount !== 8'd2) begin n_err++; $display("FAIL second_swap_frameCount: got %0d want 2", frameCount); end
    if (pixelData !== 8'hAA) begin n_err++; $display("FAIL backpressure_bank0_addr0: got %h want aa", pixelData); end
    read_at(5, v);
    n_cmp++;
    if (v !== 8'hFA) begin n_err++; $display("FAIL second_read5: got %h want fa", v); end
    read_at(200, v);
    n_cmp++;
    if (v !== 8'h37) begin n_err++; $display("FAIL second_read200: got %h want 37", v); end
  endtask

  task automatic test_resync();
    logic [7:0] v;
    feed(100, 0, 8'h11);
    frameStart = 1'b1;
    inValid    = 1'b1;
    inData     = 8'h5C;
    @(negedge clk);
    frameStart = 1'b0;
    inData     = 8'h5D;
    @(negedge clk);
    inValid = 1'b0;
    feed(FB - 3, 2, 8'h80);
    n_cmp += 2;
    if (inReady !== 1'b1)    begin n_err++; $display("FAIL resync_still_filling: got %b want 1", inReady); end
    if (frameCount !== 8'd2) begin n_err++; $display("FAIL resync_no_early_swap: got %0d want 2", frameCount); end
    sweep(1'b0, 1'b0);
    wrap_addr();
    n_cmp += 2;
    if (frameDone !== 1'b0)  begin n_err++; $display("FAIL resync_fill_wrap_frameDone: got %b want 0", frameDone); end
    if (frameCount !== 8'd2) begin n_err++; $display("FAIL resync_fill_wrap_count: got %0d want 2", frameCount); end
    feed(1, FB - 1, 8'h80);
    n_cmp++;
    if (inReady !== 1'b0) begin n_err++; $display("FAIL resync_inReady_after_last: got %b want 0", inReady); end
    sweep(1'b0, 1'b1);
    wrap_addr();
    n_cmp += 4;
    if (frameDone !== 1'b1)  begin n_err++; $display("FAIL resync_swap_frameDone: got %b want 1", frameDone); end
    if (activeBank !== 1'b1) begin n_err++; $display("FAIL resync_swap_activeBank: got %b want 1", activeBank); end
    if (frameCount !== 8'd3) begin n_err++; $display("FAIL resync_swap_frameCount: got %0d want 3", frameCount); end
    if (pixelData !== 8'h5C) begin n_err++; $display("FAIL resync_addr0: got %h want 5c", pixelData); end
    read_at(1, v);
    n_cmp++;
    if (v !== 8'h5D) begin n_err++; $display("FAIL resync_addr1: got %h want 5d", v); end
    read_at(99, v);
    n_cmp++;
    if (v !== 8'hE3) begin n_err++; $display("FAIL resync_addr99: got %h want e3", v); end
    read_at(1023, v);
    n_cmp++;
    if (v !== 8'h7F) begin n_err++; $display("FAIL resync_addr1023: got %h want 7f", v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    feed(500, 0, 8'h00);
    #2 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (inReady !== 1'b1)     begin n_err++; $display("FAIL areset_inReady: got %b want 1", inReady); end
    if (pixelData !== 8'h00)  begin n_err++; $display("FAIL areset_pixelData: got %h want 00", pixelData); end
    if (activeBank !== 1'b0)  begin n_err++; $display("FAIL areset_activeBank: got %b want 0", activeBank); end
    if (frameCount !== 8'h00) begin n_err++; $display("FAIL areset_frameCount: got %0d want 0", frameCount); end
    if (frameDone !== 1'b0)   begin n_err++; $display("FAIL areset_frameDone: got %b want 0", frameDone); end
    @(negedge clk);
    rst = 1'b0;
    pixelAddress = '0;
    sweep(1'b1, 1'b0);
    wrap_addr();
    n_cmp += 2;
    if (frameDone !== 1'b0)  begin n_err++; $display("FAIL areset_wrap_frameDone: got %b want 0", frameDone); end
    if (pixelData !== 8'h00) begin n_err++; $display("FAIL areset_wrap_pixelData: got %h want 00", pixelData); end
    feed(FB - 1, 0, 8'h33);
    n_cmp++;
    if (inReady !== 1'b1) begin n_err++; $display("FAIL areset_ptr_cleared: got %b want 1", inReady); end
    feed(1, FB - 1, 8'h33);
    n_cmp++;
    if (inReady !== 1'b0) begin n_err++; $display("FAIL areset_inReady_after_last: got %b want 0", inReady); end
    sweep(1'b1, 1'b1);
    wrap_addr();
    n_cmp += 4;
    if (frameDone !== 1'b1)  begin n_err++; $display("FAIL areset_swap_frameDone: got %b want 1", frameDone); end
    if (activeBank !== 1'b1) begin n_err++; $display("FAIL areset_swap_activeBank: got %b want 1", activeBank); end
    if (frameCount !== 8'd1) begin n_err++; $display("FAIL areset_swap_frameCount: got %0d want 1", frameCount); end
    if (pixelData !== 8'h33) begin n_err++; $display("FAIL areset_swap_addr0: got %h want 33", pixelData); end
    read_at(7, v);
    n_cmp++;
    if (v !== 8'h34) begin n_err++; $display("FAIL areset_read7: got %h want 34", v); end
  endtask

  task automatic test_counter_wrap();
    int pulses = 0;
    int extra  = 0;
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        s_inValid = 1'b1;
        s_inData  = 8'(b + f);
      end
      @(negedge clk); s_inValid = 1'b0; s_pixelAddress = 2'd1;
      @(negedge clk); s_pixelAddress = 2'd2;
      @(negedge clk); s_pixelAddress = 2'd3;
      @(negedge clk); s_pixelAddress = 2'd0;
      @(negedge clk);
      if (s_frameDone === 1'b1) pulses++;
      if (f == 254) begin
        n_cmp++;
        if (s_frameCount !== 8'd255) begin n_err++; $display("FAIL wrap_count_255: got %0d want 255", s_frameCount); end
      end
    end
    n_cmp += 3;
    if (pulses !== 256)         begin n_err++; $display("FAIL wrap_pulses: got %0d want 256", pulses); end
    if (s_frameCount !== 8'd0)  begin n_err++; $display("FAIL wrap_count_0: got %0d want 0", s_frameCount); end
    if (s_activeBank !== 1'b0)  begin n_err++; $display("FAIL wrap_activeBank: got %b want 0", s_activeBank); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      s_pixelAddress = 2'(i);
      if (s_frameDone === 1'b1) extra++;
    end
    @(negedge clk);
    if (s_frameDone === 1'b1) extra++;
    n_cmp += 2;
    if (extra !== 0)           begin n_err++; $display("FAIL fill_wrap_pulses: got %0d want 0", extra); end
    if (s_frameCount !== 8'd0) begin n_err++; $display("FAIL fill_wrap_count: got %0d want 0", s_frameCount); end
  endtask

  initial begin
    test_reset();
    test_first_frame_and_backpressure();
    test_second_frame();
    test_resync();
    test_async_reset();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
